// File: rtl/cordic_vec_ctrl.sv
// cordic_vec_ctrl: sequencer for an iterative CORDIC vectoring datapath
// Accepts operands, issues ITERATIONS micro-rotation steps, then holds the result until it is taken.
module cordic_vec_ctrl #(
  parameter int ITERATIONS = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 x_in_neg,
  input  logic                 y_sign,
  output logic                 load,
  output logic                 pre_rot,
  output logic                 iter_en,
  output logic [IDX_WIDTH-1:0] iter_idx,
  output logic                 rot_dir,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(ITERATIONS - 1);
  state_t state, state_nx;
  logic [IDX_WIDTH-1:0] idx, idx_nx;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    in_ready  = 1'b0;
    load      = 1'b0;
    pre_rot   = 1'b0;
    iter_en   = 1'b0;
    iter_idx  = '0;
    rot_dir   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
        pre_rot  = in_valid & x_in_neg;
        if (in_valid) begin
          idx_nx   = '0;
          state_nx = ITER;
        end
      end
      ITER: begin
        iter_en  = 1'b1;
        iter_idx = idx;
        rot_dir  = y_sign;
        busy     = 1'b1;
        idx_nx   = (idx == LAST) ? '0 : idx + 1'b1;
        state_nx = (idx == LAST) ? DONE : ITER;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = out_ready;
        // retiring and accepting in the same cycle avoids an idle bubble
        if (out_ready) begin
          load     = in_valid;
          pre_rot  = in_valid & x_in_neg;
          idx_nx   = '0;
          state_nx = in_valid ? ITER : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      in_ready  = 1'b0;
      load      = 1'b0;
      pre_rot   = 1'b0;
      iter_en   = 1'b0;
      iter_idx  = '0;
      rot_dir   = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
    end
  end
endmodule
